// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer:
// state encoding, opcode map and ALU operation classes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_LW    = 6'd4;
  localparam logic [5:0] OP_SW    = 6'd5;
  localparam logic [5:0] OP_BEQ   = 6'd6;
  localparam logic [5:0] OP_ITYPE = 6'd7;

  localparam logic [2:0] ALU_OP_RTYPE  = 3'd0;
  localparam logic [2:0] ALU_OP_BRANCH = 3'd1;
  localparam logic [2:0] ALU_OP_ADD    = 3'd2;
  localparam logic [2:0] ALU_OP_IMM    = 3'd3;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_ITYPE});
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    logic [2:0] r;
    r = ALU_OP_RTYPE;
    case (op)
      OP_BEQ:                 r = ALU_OP_BRANCH;
      OP_ADDI:                r = ALU_OP_ADD;
      OP_LW, OP_SW, OP_ITYPE: r = ALU_OP_IMM;
      default:                r = ALU_OP_RTYPE;
    endcase
    return r;
  endfunction

  // Immediate operand for everything except register-register ops and BEQ.
  function automatic logic alu_src_of(input logic [5:0] op);
    return !((op == OP_RTYPE) || (op == OP_BEQ));
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction/data memory request-ready handshake between the sequencer
// (master) and the memory side (slave).
interface multicycle_ctrl_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic mem_write;

  modport master (
    output imem_req, dmem_req, mem_write,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, mem_write,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// Wait-cycle watchdog shared by the fetch and data-memory states; counts
// consecutive stalled cycles and flags when the limit is reached.
module ctrl_wait_timer #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_i,
  output logic limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Only a stalled cycle can hit the limit, so a ready in that cycle wins.
  assign limit_o = (WAIT_LIMIT != 0) && wait_i && (cnt_q == CNT_W'(WAIT_LIMIT));

  always_comb begin
    cnt_d = '0;
    if (wait_i && !limit_o) begin
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes and a wait watchdog. Define ILLEGAL_OP_TRAP_EN to trap on illegal opcodes.
module multicycle_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int ALU_OP_W   = 3,
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  mem_if,
  input  logic [OPCODE_W-1:0]    opcode,
  input  logic                   zero,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_src,
  output logic                   reg_dst,
  output logic                   alu_src,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic [ALU_OP_W-1:0]    alu_op,
  output logic                   instr_done,
  output logic                   bus_error,
  output logic                   trap
);

  state_e     state_q, state_d;
  logic       bus_err_q, bus_err_d;
  logic       trap_q, trap_d;
  logic [5:0] op;
  logic       waiting;
  logic       timeout;
  logic       imem_req_c, dmem_req_c, mem_write_c;
  logic [2:0] alu_op_c;

  assign op = 6'(opcode);

  assign waiting = ((state_q == ST_FETCH) && !mem_if.imem_ready) ||
                   ((state_q == ST_MEM)   && !mem_if.dmem_ready);

  ctrl_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wait_i  (waiting),
    .limit_o (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bus_err_q <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
      trap_q    <= trap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_err_d   = bus_err_q;
    trap_d      = trap_q;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_op_c    = '0;
    instr_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (mem_if.imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          trap_d    = 1'b1;
          state_d   = ST_TRAP;
        end
      end

      ST_DECODE: begin
        if (is_legal_op(op)) begin
          state_d = ST_EXEC;
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
          trap_d  = 1'b1;
          state_d = ST_TRAP;
`else
          instr_done = 1'b1;
          state_d    = ST_FETCH;
`endif
        end
      end

      ST_EXEC: begin
        alu_src  = alu_src_of(op);
        alu_op_c = alu_op_of(op);
        if (op == OP_BEQ) begin
          pc_src     = 1'b1;
          pc_write   = zero;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      // ALU controls stay at their EXEC values so the address is held.
      ST_MEM: begin
        dmem_req_c  = 1'b1;
        mem_write_c = (op == OP_SW);
        alu_src     = alu_src_of(op);
        alu_op_c    = alu_op_of(op);
        if (mem_if.dmem_ready) begin
          if (op == OP_SW) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          bus_err_d = 1'b1;
          trap_d    = 1'b1;
          state_d   = ST_TRAP;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op == OP_RTYPE);
        mem_to_reg = (op == OP_LW);
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_if.imem_req  = imem_req_c;
  assign mem_if.dmem_req  = dmem_req_c;
  assign mem_if.mem_write = mem_write_c;
  assign alu_op           = ALU_OP_W'(alu_op_c);
  assign bus_error        = bus_err_q;
  assign trap             = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle checks of the full
// control vector for each instruction class, watchdog and reset behaviour.
module tb_multicycle_ctrl_fsm;
  import mips_ctrl_pkg::*;

  localparam logic [15:0] IREQ = 16'h8000;
  localparam logic [15:0] DREQ = 16'h4000;
  localparam logic [15:0] MW   = 16'h2000;
  localparam logic [15:0] IRW  = 16'h1000;
  localparam logic [15:0] PCW  = 16'h0800;
  localparam logic [15:0] PCS  = 16'h0400;
  localparam logic [15:0] RDST = 16'h0200;
  localparam logic [15:0] ASRC = 16'h0100;
  localparam logic [15:0] M2R  = 16'h0080;
  localparam logic [15:0] RW   = 16'h0040;
  localparam logic [15:0] A1   = 16'h0008;
  localparam logic [15:0] A2   = 16'h0010;
  localparam logic [15:0] A3   = 16'h0018;
  localparam logic [15:0] DONE = 16'h0004;
  localparam logic [15:0] BERR = 16'h0002;
  localparam logic [15:0] TRP  = 16'h0001;
  localparam logic [15:0] FET  = IREQ | IRW | PCW;
  localparam logic [15:0] SWM  = DREQ | MW | ASRC | A3;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       ir_write, pc_write, pc_src, reg_dst, alu_src;
  logic       mem_to_reg, reg_write, instr_done, bus_error, trap;
  logic [2:0] alu_op;
  logic [15:0] outs;
  int         checks = 0;
  int         errors = 0;

  multicycle_ctrl_fsm_if mif ();

  multicycle_ctrl_fsm #(
    .OPCODE_W   (6),
    .ALU_OP_W   (3),
    .WAIT_LIMIT (4),
    .CNT_W      (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_if     (mif),
    .opcode     (opcode),
    .zero       (zero),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .bus_error  (bus_error),
    .trap       (trap)
  );

  assign outs = {mif.imem_req, mif.dmem_req, mif.mem_write, ir_write, pc_write,
                 pc_src, reg_dst, alu_src, mem_to_reg, reg_write, alu_op,
                 instr_done, bus_error, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: check mid-cycle, then advance one cycle.
  task automatic step(input string tag, input logic [15:0] exp);
    @(negedge clk);
    chk(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk(tag, outs, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step({tag, "_idle"}, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'd0;
    zero = 1'b0;
    mif.imem_ready = 1'b1;
    mif.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs, 16'h0000);
    rst_n = 1'b1;
    step("idle", 16'h0000);

    // R-type, zero-wait fetch: 4 cycles
    opcode = OP_RTYPE;
    step("r_fetch", FET);
    step("r_decode", 16'h0000);
    step("r_exec", 16'h0000);
    step("r_wb", RW | RDST | DONE);

    // LW, imem 2 waits, dmem 3 waits: 10 cycles
    opcode = OP_LW;
    mif.imem_ready = 1'b0;
    step("lw_fetch_w0", IREQ);
    step("lw_fetch_w1", IREQ);
    mif.imem_ready = 1'b1;
    step("lw_fetch", FET);
    step("lw_decode", 16'h0000);
    step("lw_exec", ASRC | A3);
    for (int i = 0; i < 3; i++) step("lw_mem_wait", DREQ | ASRC | A3);
    mif.dmem_ready = 1'b1;
    step("lw_mem", DREQ | ASRC | A3);
    mif.dmem_ready = 1'b0;
    step("lw_wb", RW | M2R | DONE);

    // BEQ taken and not taken: 3 cycles each
    opcode = OP_BEQ;
    zero = 1'b1;
    step("beq1_fetch", FET);
    step("beq1_decode", 16'h0000);
    step("beq1_exec", A1 | PCS | PCW | DONE);
    zero = 1'b0;
    step("beq0_fetch", FET);
    step("beq0_decode", 16'h0000);
    step("beq0_exec", A1 | PCS | DONE);

    // ADDI and I-type ALU
    opcode = OP_ADDI;
    step("addi_fetch", FET);
    step("addi_decode", 16'h0000);
    step("addi_exec", ASRC | A2);
    step("addi_wb", RW | DONE);
    opcode = OP_ITYPE;
    step("itype_fetch", FET);
    step("itype_decode", 16'h0000);
    step("itype_exec", ASRC | A3);
    step("itype_wb", RW | DONE);

    // SW, zero-wait: 4 cycles
    opcode = OP_SW;
    mif.dmem_ready = 1'b1;
    step("sw_fetch", FET);
    step("sw_decode", 16'h0000);
    step("sw_exec", ASRC | A3);
    step("sw_mem", SWM | DONE);

    // SW with ready arriving exactly at the limit: no error
    mif.dmem_ready = 1'b0;
    step("swl_fetch", FET);
    step("swl_decode", 16'h0000);
    step("swl_exec", ASRC | A3);
    for (int i = 0; i < 4; i++) step("swl_mem_wait", SWM);
    mif.dmem_ready = 1'b1;
    step("swl_mem", SWM | DONE);
    mif.dmem_ready = 1'b0;

    // Reset asserted during MEM of SW drops requests asynchronously
    step("swr_fetch", FET);
    step("swr_decode", 16'h0000);
    step("swr_exec", ASRC | A3);
    @(negedge clk);
    chk("swr_mem", outs, SWM);
    #2;
    rst_n = 1'b0;
    #1;
    chk("swr_async_rst", outs, 16'h0000);
    @(posedge clk);
    #1;
    chk("swr_rst_hold", outs, 16'h0000);
    rst_n = 1'b1;
    step("swr_idle", 16'h0000);

    // Illegal opcode
    opcode = 6'd9;
    step("ill_fetch", FET);
`ifdef ILLEGAL_OP_TRAP_EN
    step("ill_decode", 16'h0000);
    step("ill_trap", TRP);
    step("ill_trap_stuck", TRP);
`else
    step("ill_decode", DONE);
    step("ill_refetch", FET);
`endif
    reset_pulse("ill_rst");

    // SW timeout: 5 MEM cycles, then TRAP until reset
    opcode = OP_SW;
    step("swt_fetch", FET);
    step("swt_decode", 16'h0000);
    step("swt_exec", ASRC | A3);
    for (int i = 0; i < 5; i++) step("swt_mem_wait", SWM);
    step("swt_trap", BERR | TRP);
    mif.dmem_ready = 1'b1;
    step("swt_trap_stuck", BERR | TRP);
    step("swt_trap_stuck2", BERR | TRP);
    mif.dmem_ready = 1'b0;
    reset_pulse("swt_rst");
    step("swt_restart_fetch", FET);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath. One instruction executes over 3–5 states instead of one cycle.
- Decodes opcode and drives the same datapath control set as the single-cycle decoder.
- Adds PC/IR write enables and pc_src.
- Adds req/ready handshakes to instruction and data memory, plus a wait-timeout watchdog.
- Sits between the IR/PC registers and the ALU, register file and memories.

Parameters:
- OPCODE_W, 6, opcode width.
- ALU_OP_W, 3, alu_op width.
- WAIT_LIMIT, 16, maximum consecutive cycles waiting on any ready; 0 disables the watchdog.
- CNT_W, 5, wait counter width; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  opcode field of IR; stable from DECODE onward.
- zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction word valid.
- dmem_ready  in  1  data access complete; read data valid.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- mem_write  out  1  data write qualifier; asserted only together with dmem_req.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg_dst  out  1  1 = rd, 0 = rt.
- alu_src  out  1  1 = immediate.
- mem_to_reg  out  1  writeback source is memory.
- reg_write  out  1  register file write enable.
- alu_op  out  ALU_OP_W  ALU operation class.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- bus_error  out  1  sticky watchdog flag.
- trap  out  1  sticky; the FSM is halted.

Behaviour:
- Opcode map:
  - 0 = R-type.
  - 1 = ADDI.
  - 4 = LW.
  - 5 = SW.
  - 6 = BEQ.
  - 7 = I-type ALU.
  - Every other value is illegal.
- alu_op by opcode: 0 → 0, 6 → 1, 1 → 2, 4/5/7 → 3.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state; outputs decoded combinationally from state and opcode.
- Reset: state = IDLE, counter = 0, bus_error = 0, trap = 0. All outputs are 0 while in IDLE. IDLE → FETCH unconditionally on the next edge.
- FETCH:
  - imem_req = 1 and held until imem_ready.
  - In the ready cycle: ir_write = 1, pc_write = 1, pc_src = 0; next state DECODE.
- DECODE: no enables asserted. Legal opcode → EXEC. Illegal opcode → see Optional Feature.
- EXEC: alu_src = 0 for opcodes 0 and 6, else 1; alu_op per the map.
  - BEQ: pc_src = 1, pc_write = zero, instr_done = 1; next FETCH.
  - LW/SW: next MEM.
  - Others: next WB.
- MEM:
  - dmem_req = 1; mem_write = 1 for SW. alu_src/alu_op held at their EXEC values.
  - Wait for dmem_ready.
  - SW: instr_done = 1 in the ready cycle; next FETCH.
  - LW: next WB.
- WB: reg_write = 1, reg_dst = (opcode == 0), mem_to_reg = (opcode == 4), instr_done = 1; next FETCH.
- Cycle counts with zero-wait memories: R/ADDI/I = 4, LW = 5, SW = 4, BEQ = 3. Each wait cycle adds 1.
- Watchdog:
  - Counter increments each cycle that a req is high and its ready is low; clears when ready arrives or on leaving the state.
  - When counter == WAIT_LIMIT with ready still low (WAIT_LIMIT ≠ 0): set bus_error, go to TRAP, drop req.
  - A ready arriving in the same cycle as the limit wins: normal transition, no error.
- TRAP: all outputs 0 except trap/bus_error. Left only by reset.
- Reset asserted mid-operation (any state): immediate return to IDLE with outputs 0; no partial reg_write/mem_write is issued.
- zero is ignored outside EXEC. ready inputs are ignored outside their own state.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an illegal opcode in DECODE sets trap and goes to TRAP.
- Undefined: an illegal opcode is a NOP. DECODE → FETCH with instr_done = 1; trap stays 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_RTYPE/OP_ADDI/OP_LW/OP_SW/OP_BEQ/OP_ITYPE;
  - alu_op constants.
- Sub-module ctrl_wait_timer (counter, clear, limit-compare) is instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset release, R-type, imem_ready immediate → imem_req in cycle 1; ir_write + pc_write in cycle 1; reg_write = 1, reg_dst = 1 in cycle 4; instr_done pulse in cycle 4.
- LW with imem_ready delayed 2 and dmem_ready delayed 3 → 10 cycles total; mem_to_reg = 1 and reg_write = 1 only in the final cycle; mem_write never asserted.
- BEQ: zero = 1 → pc_src = 1 and pc_write = 1 in EXEC. zero = 0 → pc_write = 0. Both retire in 3 cycles.
- SW with WAIT_LIMIT = 4 and dmem_ready never asserted → bus_error and trap set after 4 wait cycles; dmem_req drops; remains stuck until rst_n pulse.
- Opcode 9:
  - with ILLEGAL_OP_TRAP_EN → trap = 1 in the cycle after DECODE;
  - without it → instr_done in DECODE, next state FETCH.
- rst_n low during MEM of SW → dmem_req and mem_write drop to 0 asynchronously; after release, IDLE then FETCH.
